// File: rtl/ebus_ctl_if.sv
// EBUS device-side signal bundle: controller select, function, data and the demand/transfer handshake.
// The controller side is the master; a device (or a bench device model) is the slave.
interface ebus_ctl_if;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusDemand;
  logic [35:0] ebusDOut;
  logic        ebusDOutEn;
  logic        ebusXfer;
  logic [35:0] ebusDIn;

  modport master (
    output ebusCS, ebusFunc, ebusDemand, ebusDOut, ebusDOutEn,
    input  ebusXfer, ebusDIn
  );

  modport slave (
    input  ebusCS, ebusFunc, ebusDemand, ebusDOut, ebusDOutEn,
    output ebusXfer, ebusDIn
  );
endinterface

// File: rtl/ebus_ctl.sv
// EBUS sequencer/arbiter for EBOX and front-end: round-robin grant, demand/xfer handshake with timeouts.
// Latency grant->Return is 5 cycles minimum; requesters are held off by their Grant staying low until their turn.
module ebus_ctl #(
  parameter int TIMEOUT = 32,
  parameter int RELWAIT = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        eboxReq,
  input  logic [6:0]  eboxCS,
  input  logic [2:0]  eboxFunc,
  input  logic [35:0] eboxDOut,
  input  logic        feReq,
  input  logic [6:0]  feCS,
  input  logic [2:0]  feFunc,
  input  logic [35:0] feDOut,
  ebus_ctl_if.master  bus,
  output logic        eboxGrant,
  output logic        feGrant,
  output logic [35:0] readData,
  output logic        eboxReturn,
  output logic        feReturn,
  output logic        timeoutErr
);

  localparam int CMAX = (TIMEOUT > RELWAIT) ? TIMEOUT : RELWAIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RLAST = CW'(RELWAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DEMAND,
    LATCH,
    RELEASE,
    DONE
  } state_t;

  state_t      state;
  state_t      nextState;

  logic        ownerFe;
  logic        lastFe;
  logic [6:0]  regCS;
  logic [2:0]  regFunc;
  logic [35:0] regData;
  logic [CW-1:0] cnt;
  logic        abort;

  logic        grabReq;
  logic        pickFe;
  logic        cntClr;
  logic        cntInc;
  logic        abortSet;
  logic        latchEn;
  logic        onBus;
  logic        demandOut;
  logic        dOutEnOut;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    grabReq    = 1'b0;
    pickFe     = 1'b0;
    cntClr     = 1'b0;
    cntInc     = 1'b0;
    abortSet   = 1'b0;
    latchEn    = 1'b0;
    onBus      = 1'b0;
    demandOut  = 1'b0;
    dOutEnOut  = 1'b0;
    eboxGrant  = 1'b0;
    feGrant    = 1'b0;
    eboxReturn = 1'b0;
    feReturn   = 1'b0;
    timeoutErr = 1'b0;

    case (state)
      IDLE: begin
        if (eboxReq || feReq) begin
          grabReq   = 1'b1;
          // On a tie the requester that did not own the bus last time wins.
          pickFe    = feReq && (!eboxReq || !lastFe);
          nextState = SETUP;
        end
      end
      SETUP: begin
        onBus     = 1'b1;
        dOutEnOut = !regFunc[2];
        cntClr    = 1'b1;
        nextState = DEMAND;
      end
      DEMAND: begin
        onBus     = 1'b1;
        demandOut = 1'b1;
        dOutEnOut = !regFunc[2];
        if (bus.ebusXfer) begin
          nextState = LATCH;
        end else if (cnt == TLAST) begin
          abortSet  = 1'b1;
          cntClr    = 1'b1;
          nextState = RELEASE;
        end else begin
          cntInc = 1'b1;
        end
      end
      LATCH: begin
        onBus     = 1'b1;
        demandOut = 1'b1;
        dOutEnOut = !regFunc[2];
        latchEn   = regFunc[2];
        cntClr    = 1'b1;
        nextState = RELEASE;
      end
      RELEASE: begin
        onBus = 1'b1;
        if (!bus.ebusXfer) begin
          nextState = DONE;
        end else if (cnt == RLAST) begin
          // Device never let go of xfer; finish anyway and flag it.
          abortSet  = 1'b1;
          nextState = DONE;
        end else begin
          cntInc = 1'b1;
        end
      end
      DONE: begin
        eboxReturn = !ownerFe;
        feReturn   = ownerFe;
        timeoutErr = abort;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase

    if (state != IDLE) begin
      eboxGrant = !ownerFe;
      feGrant   = ownerFe;
    end
  end

  assign bus.ebusCS     = onBus ? regCS   : '0;
  assign bus.ebusFunc   = onBus ? regFunc : '0;
  assign bus.ebusDOut   = onBus ? regData : '0;
  assign bus.ebusDemand = demandOut;
  assign bus.ebusDOutEn = dOutEnOut;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ownerFe  <= 1'b0;
      lastFe   <= 1'b1;
      regCS    <= '0;
      regFunc  <= '0;
      regData  <= '0;
      cnt      <= '0;
      abort    <= 1'b0;
      readData <= '0;
    end else begin
      if (grabReq) begin
        ownerFe <= pickFe;
        regCS   <= pickFe ? feCS    : eboxCS;
        regFunc <= pickFe ? feFunc  : eboxFunc;
        regData <= pickFe ? feDOut  : eboxDOut;
      end

      if (cntClr) begin
        cnt <= '0;
      end else if (cntInc) begin
        cnt <= cnt + CW'(1);
      end

      if (state == DONE) begin
        abort  <= 1'b0;
        lastFe <= ownerFe;
      end else if (abortSet) begin
        abort <= 1'b1;
      end

      if (latchEn) begin
        readData <= bus.ebusDIn;
      end
    end
  end

endmodule

// File: tb/tb_ebus_ctl.sv
// Directed bench for ebus_ctl: table of single transactions plus arbitration and async-reset sequences.
module tb_ebus_ctl;

  logic        clk;
  logic        rstN;
  logic        eboxReq;
  logic [6:0]  eboxCS;
  logic [2:0]  eboxFunc;
  logic [35:0] eboxDOut;
  logic        feReq;
  logic [6:0]  feCS;
  logic [2:0]  feFunc;
  logic [35:0] feDOut;
  logic        eboxGrant;
  logic        feGrant;
  logic [35:0] readData;
  logic        eboxReturn;
  logic        feReturn;
  logic        timeoutErr;

  ebus_ctl_if bus ();

  ebus_ctl #(.TIMEOUT(32), .RELWAIT(8)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .eboxReq    (eboxReq),
    .eboxCS     (eboxCS),
    .eboxFunc   (eboxFunc),
    .eboxDOut   (eboxDOut),
    .feReq      (feReq),
    .feCS       (feCS),
    .feFunc     (feFunc),
    .feDOut     (feDOut),
    .bus        (bus),
    .eboxGrant  (eboxGrant),
    .feGrant    (feGrant),
    .readData   (readData),
    .eboxReturn (eboxReturn),
    .feReturn   (feReturn),
    .timeoutErr (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          useFe;
    logic [6:0]  cs;
    logic [2:0]  func;
    logic [35:0] dout;
    int          ack;      // demand cycles before xfer; 0 = already high, -1 = never
    bit          stuck;    // xfer stays high after demand drops
    logic [35:0] din;
    int          expDem;
    int          expEn;
    int          expErr;
    int          expLat;
    logic [35:0] expRead;
  } vec_t;

  vec_t vecs[6];

  int total = 0;
  int bad   = 0;

  int ackDelay;
  bit stuck;
  bit rearm;
  bit pendE;
  bit pendF;
  int demAge;
  int demCyc, enCyc, errCnt, retE, retF, grantE, grantF, nRet;
  int ordArr[8];
  logic [6:0]  seenCS;
  logic [2:0]  seenFunc;
  logic [35:0] seenDOut;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clearStats();
    demAge = 0; demCyc = 0; enCyc = 0; errCnt = 0;
    retE = 0; retF = 0; grantE = 0; grantF = 0; nRet = 0;
    pendE = 0; pendF = 0;
    for (int i = 0; i < 8; i++) ordArr[i] = 9;
    seenCS = '0; seenFunc = '0; seenDOut = '0;
  endtask

  // One clock: sample outputs #1 after the edge, then act as device and requesters.
  task automatic step();
    @(posedge clk);
    #1;
    if (eboxGrant)      grantE++;
    if (feGrant)        grantF++;
    if (bus.ebusDOutEn) enCyc++;
    if (timeoutErr)     errCnt++;
    if (bus.ebusDemand) begin
      demCyc++;
      demAge++;
      if (demAge == 1) begin
        seenCS   = bus.ebusCS;
        seenFunc = bus.ebusFunc;
        seenDOut = bus.ebusDOut;
      end
      if (ackDelay >= 0 && demAge >= ackDelay) bus.ebusXfer = 1'b1;
    end else if (demAge > 0 && !stuck) begin
      bus.ebusXfer = 1'b0;
    end
    if (pendE) begin eboxReq = 1'b1; pendE = 0; end
    if (pendF) begin feReq   = 1'b1; pendF = 0; end
    if (eboxReturn) begin
      retE++;
      if (nRet < 8) ordArr[nRet] = 0;
      nRet++;
      eboxReq = 1'b0; pendE = rearm; demAge = 0;
      if (stuck) bus.ebusXfer = 1'b0;
    end
    if (feReturn) begin
      retF++;
      if (nRet < 8) ordArr[nRet] = 1;
      nRet++;
      feReq = 1'b0; pendF = rearm; demAge = 0;
      if (stuck) bus.ebusXfer = 1'b0;
    end
  endtask

  task automatic runUntilRet(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while ((retE + retF) < n && k < budget) begin
      step();
      k++;
    end
    chk({nm, " return within budget"}, 64'((retE + retF) >= n), 64'd1);
  endtask

  initial begin
    vecs[0] = '{0, 7'o014, 3'b001, 36'o123456_654321, 2,  0, 36'o0,              3,  4, 0, 6,  36'o0};
    vecs[1] = '{1, 7'o020, 3'b101, 36'o0,             1,  0, 36'o777000_000777,  2,  0, 0, 5,  36'o777000_000777};
    vecs[2] = '{0, 7'o100, 3'b000, 36'o1,             0,  0, 36'o0,              2,  3, 0, 5,  36'o777000_000777};
    vecs[3] = '{0, 7'o004, 3'b100, 36'o0,             -1, 0, 36'o55,             32, 0, 1, 35, 36'o777000_000777};
    vecs[4] = '{1, 7'o177, 3'b011, 36'o707070_707070, 2,  1, 36'o0,              3,  4, 1, 13, 36'o777000_000777};
    vecs[5] = '{1, 7'o036, 3'b101, 36'o0,             3,  0, 36'o000111_222333,  4,  0, 0, 7,  36'o000111_222333};

    rstN = 1'b0;
    eboxReq = 1'b0; eboxCS = '0; eboxFunc = '0; eboxDOut = '0;
    feReq = 1'b0; feCS = '0; feFunc = '0; feDOut = '0;
    bus.ebusXfer = 1'b0; bus.ebusDIn = '0;
    ackDelay = 1; stuck = 0; rearm = 0;
    clearStats();

    repeat (3) @(posedge clk);
    #1;
    chk("reset grants", {62'd0, eboxGrant, feGrant}, 64'd0);
    chk("reset demand/en", {62'd0, bus.ebusDemand, bus.ebusDOutEn}, 64'd0);
    chk("reset cs/func", {54'd0, bus.ebusCS, bus.ebusFunc}, 64'd0);
    chk("reset dout", 64'(bus.ebusDOut), 64'd0);
    chk("reset returns", {61'd0, eboxReturn, feReturn, timeoutErr}, 64'd0);
    chk("reset readData", 64'(readData), 64'd0);
    rstN = 1'b1;

    // Both requesters rise together and keep re-requesting: EBOX, FE, EBOX, FE.
    step();
    clearStats();
    eboxCS = 7'o001; eboxFunc = 3'b001; eboxDOut = 36'o11;
    feCS   = 7'o002; feFunc   = 3'b001; feDOut   = 36'o22;
    ackDelay = 1; stuck = 0; rearm = 1;
    eboxReq = 1'b1; feReq = 1'b1;
    runUntilRet("rr", 4, 200);
    rearm = 0; pendE = 0; pendF = 0;
    eboxReq = 1'b0; feReq = 1'b0;
    chk("rr grant 1 ebox", 64'(ordArr[0]), 64'd0);
    chk("rr grant 2 fe",   64'(ordArr[1]), 64'd1);
    chk("rr grant 3 ebox", 64'(ordArr[2]), 64'd0);
    chk("rr grant 4 fe",   64'(ordArr[3]), 64'd1);
    chk("rr no timeout", 64'(errCnt), 64'd0);
    repeat (3) step();

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      clearStats();
      ackDelay = vecs[v].ack;
      stuck    = vecs[v].stuck;
      bus.ebusXfer = (vecs[v].ack == 0);
      bus.ebusDIn  = vecs[v].din;
      if (vecs[v].useFe) begin
        feCS = vecs[v].cs; feFunc = vecs[v].func; feDOut = vecs[v].dout; feReq = 1'b1;
      end else begin
        eboxCS = vecs[v].cs; eboxFunc = vecs[v].func; eboxDOut = vecs[v].dout; eboxReq = 1'b1;
      end
      runUntilRet(tag, 1, 100);
      repeat (3) step();
      bus.ebusXfer = 1'b0;
      chk({tag, " owner return"},  64'(vecs[v].useFe ? retF : retE), 64'd1);
      chk({tag, " other return"},  64'(vecs[v].useFe ? retE : retF), 64'd0);
      chk({tag, " other grant"},   64'(vecs[v].useFe ? grantE : grantF), 64'd0);
      chk({tag, " grant->return"}, 64'(vecs[v].useFe ? grantF : grantE), 64'(vecs[v].expLat));
      chk({tag, " demand cycles"}, 64'(demCyc), 64'(vecs[v].expDem));
      chk({tag, " douten cycles"}, 64'(enCyc), 64'(vecs[v].expEn));
      chk({tag, " timeoutErr"},    64'(errCnt), 64'(vecs[v].expErr));
      chk({tag, " bus cs"},        64'(seenCS), 64'(vecs[v].cs));
      chk({tag, " bus func"},      64'(seenFunc), 64'(vecs[v].func));
      chk({tag, " bus dout"},      64'(seenDOut), 64'(vecs[v].dout));
      chk({tag, " readData"},      64'(readData), 64'(vecs[v].expRead));
    end

    // Async reset while the device is being demanded.
    clearStats();
    ackDelay = -1; stuck = 0;
    eboxCS = 7'o055; eboxFunc = 3'b001; eboxDOut = 36'o5;
    eboxReq = 1'b1;
    begin
      int k;
      k = 0;
      while (!bus.ebusDemand && k < 10) begin
        step();
        k++;
      end
    end
    chk("rst: demand reached", 64'(bus.ebusDemand), 64'd1);
    rstN = 1'b0;
    #1;
    chk("rst: demand drop", 64'(bus.ebusDemand), 64'd0);
    chk("rst: grant drop", 64'(eboxGrant), 64'd0);
    chk("rst: cs drop", 64'(bus.ebusCS), 64'd0);
    chk("rst: readData clr", 64'(readData), 64'd0);
    eboxReq = 1'b0;
    retE = 0; retF = 0;
    repeat (3) step();
    chk("rst: no return", 64'(retE + retF), 64'd0);
    rstN = 1'b1;

    clearStats();
    ackDelay = 1; stuck = 0;
    bus.ebusDIn = 36'o246_135;
    feCS = 7'o020; feFunc = 3'b101; feDOut = '0;
    feReq = 1'b1;
    runUntilRet("post-rst", 1, 100);
    repeat (2) step();
    chk("post-rst fe return", 64'(retF), 64'd1);
    chk("post-rst readData", 64'(readData), 64'(36'o246_135));
    chk("post-rst latency", 64'(grantF), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
